mips_ctrl_pipe: RTL and testbench
=================================

// Module: mips_ctrl_pipe
// PURPOSE
//  Consumer of the main decoder's control bundle. Carries decoded controls for the 5-stage pipeline ID->EX->MEM->WB.
//  Detects load-use hazards (stall), resolves beq/bne in EX (flush), and produces EX-stage forwarding selects.
//  Sits between the decoder/register-file read in ID and the datapath stage registers.
// PARAMETERS
//  RA_W    5   register-address width
//  PERF_W  32  perf counter width (used only with CTRL_PIPE_PERF_EN)
// PORTS
//  clk          in   1     pipeline clock; all state on rising edge
//  reset        in   1     synchronous, active-high; clears all stage state
//  id_valid     in   1     instruction in ID is real (0 = bubble)
//  id_ctrl      in   ctrl_t  {regwrite,regdst,alusrc,branch,bne,memwrite,memtoreg,jump,aluop[1:0]} from decoder
//  id_rs,id_rt,id_rd in RA_W  register fields of ID instruction
//  ex_zero      in   1     ALU zero flag of the instruction in EX
//  stall_f,stall_d out 1  hold PC / IF-ID register
//  flush_d      out  1     clear IF-ID register (taken branch or jump)
//  pcsrc_e      out  1     select branch target for PC
//  jump_d       out  1     id_valid & id_ctrl.jump
//  ex_alusrc    out  1     EX-stage alusrc
//  ex_aluop     out  2     EX-stage aluop
//  ex_regdst    out  1     EX-stage regdst
//  fwd_a_e,fwd_b_e out 2   00 regfile, 10 from MEM, 01 from WB
//  mem_memwrite,mem_regwrite,mem_memtoreg out 1 MEM-stage controls
//  mem_writereg out  RA_W
//  wb_regwrite,wb_memtoreg out 1  WB-stage controls
//  wb_writereg  out  RA_W
// BEHAVIOUR
//  - Reset: every stage valid=0, every stored control and register number =0. All outputs read 0 the cycle after reset is sampled.
//  - Reset mid-stream discards all in-flight instructions; no partial writes.
//  - Latency: ID controls in cycle N appear on ex_* in N+1, mem_* in N+2, wb_* in N+3.
//  - Every output control is gated by its stage valid; a bubble never asserts regwrite, memwrite, branch or bne.
//  - ex_writereg = ex_regdst ? ex_rd : ex_rt, registered into MEM, then into WB.
//  - Load-use:
//      lu = ex_valid & ex_memtoreg & ex_writereg!=0 & (ex_writereg==id_rs | ex_writereg==id_rt)
//      Conservative: rt is compared even for I-type. lu -> stall_f=stall_d=1 and a bubble enters EX next cycle; ID holds.
//  - Branch: pcsrc_e = ex_valid & ((ex_branch & ex_zero) | (ex_bne & ~ex_zero)).
//      pcsrc_e -> flush_d=1 and a bubble enters EX next cycle.
//  - Jump: jump_d -> flush_d=1; the jump itself proceeds as a no-write instruction.
//  - Priority for EX load: reset > pcsrc_e > lu > normal. lu and pcsrc_e cannot coexist (a branch is not a load).
//      If both assert, flush wins and stall_f=stall_d=0.
//  - Forwarding A (B identical with ex_rt):
//      10 if mem_valid & mem_regwrite & mem_writereg!=0 & mem_writereg==ex_rs
//      else 01 if wb_valid & wb_regwrite & wb_writereg!=0 & wb_writereg==ex_rs
//      else 00. MEM beats WB on a double match. $0 is never forwarded.
//  - MEM->WB and EX->MEM always advance; only ID->EX is modified by stall/flush.
// CONFIGURATION
//  CTRL_PIPE_PERF_EN defined: adds outputs perf_stall, perf_flush, perf_retired (PERF_W each).
//      Counts cycles with lu, cycles with flush_d, and WB-valid cycles. Saturating; cleared by reset.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package mips_ctrl_pkg: ctrl_t packed struct; aluop_t enum (ADD=00, SUB=01, FUNCT=10); fwd_t constants (REGF/WB/MEM).
//  Sub-module mips_ctrl_stage_reg: ctrl_t + valid + register-number register with en/clr.
//      Instantiated per stage: ID/EX, EX/MEM, MEM/WB.
// TESTING
//  1. Reset held 2 cycles mid-stream with LW in EX -> all outputs 0 next cycle; no mem_regwrite afterwards.
//  2. LW $2 then ADD $3,$2,$4 -> one cycle stall_f=stall_d=1, bubble in EX, then fwd_a_e=01 for the ADD.
//  3. ADD $5 then SUB using $5 as rs and rt -> fwd_a_e=fwd_b_e=10. With $0 as dest -> 00.
//  4. BEQ, ex_zero=1 -> pcsrc_e=1, flush_d=1, bubble in EX. BNE, ex_zero=1 -> pcsrc_e=0.
//  5. J in ID -> jump_d=1, flush_d=1; 3 cycles later wb_regwrite=0.
//  6. Back-to-back ADD writing $7 in MEM and WB -> fwd=10 (MEM priority); perf_retired increments per WB-valid cycle.

Source files
------------

// File: rtl/mips_ctrl_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
//   Shared types for the MIPS pipeline control slice.
//   - ctrl_t : decoded control bundle produced by the main decoder in ID
//   - aluop_t: ALU operation class carried in ctrl_t.aluop
//   - fwd_t  : EX-stage operand forwarding select (REGF / WB / MEM)
//   - fwd_select(): priority encoder for the forwarding select
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    // Decoded controls, MSB first in the order the decoder emits them.
    typedef struct packed {
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       branch;
        logic       bne;
        logic       memwrite;
        logic       memtoreg;
        logic       jump;
        logic [1:0] aluop;
    } ctrl_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef logic [1:0] fwd_t;

    localparam fwd_t FWD_REGF = 2'b00;
    localparam fwd_t FWD_WB   = 2'b01;
    localparam fwd_t FWD_MEM  = 2'b10;

    // The younger producer (MEM) holds the newer value, so it wins a double match.
    function automatic fwd_t fwd_select(input logic mem_hit, input logic wb_hit);
        fwd_t sel;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_REGF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mips_ctrl_pipe_if.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pipe_if
//   Bundles the ID-side inputs and all pipeline-control outputs of
//   mips_ctrl_pipe.
//   modport slave : the control pipe (reads ID fields, drives controls)
//   modport master: the decoder/datapath side (drives ID fields, reads controls)
//   Optional macro CTRL_PIPE_PERF_EN adds perf_stall/perf_flush/perf_retired.
// -----------------------------------------------------------------------------
interface mips_ctrl_pipe_if
    import mips_ctrl_pkg::*;
#(
    parameter int RA_W   = 5,
    parameter int PERF_W = 32
);

    // ID-side inputs
    logic            id_valid;
    ctrl_t           id_ctrl;
    logic [RA_W-1:0] id_rs;
    logic [RA_W-1:0] id_rt;
    logic [RA_W-1:0] id_rd;
    logic            ex_zero;

    // Hazard / redirect outputs
    logic            stall_f;
    logic            stall_d;
    logic            flush_d;
    logic            pcsrc_e;
    logic            jump_d;

    // EX-stage outputs
    logic            ex_alusrc;
    logic [1:0]      ex_aluop;
    logic            ex_regdst;
    fwd_t            fwd_a_e;
    fwd_t            fwd_b_e;

    // MEM-stage outputs
    logic            mem_memwrite;
    logic            mem_regwrite;
    logic            mem_memtoreg;
    logic [RA_W-1:0] mem_writereg;

    // WB-stage outputs
    logic            wb_regwrite;
    logic            wb_memtoreg;
    logic [RA_W-1:0] wb_writereg;

`ifdef CTRL_PIPE_PERF_EN
    logic [PERF_W-1:0] perf_stall;
    logic [PERF_W-1:0] perf_flush;
    logic [PERF_W-1:0] perf_retired;
`else
    localparam int perf_w_unused = PERF_W;
`endif

    modport slave (
`ifdef CTRL_PIPE_PERF_EN
        output perf_stall, perf_flush, perf_retired,
`endif
        input  id_valid, id_ctrl, id_rs, id_rt, id_rd, ex_zero,
        output stall_f, stall_d, flush_d, pcsrc_e, jump_d,
        output ex_alusrc, ex_aluop, ex_regdst, fwd_a_e, fwd_b_e,
        output mem_memwrite, mem_regwrite, mem_memtoreg, mem_writereg,
        output wb_regwrite, wb_memtoreg, wb_writereg
    );

    modport master (
`ifdef CTRL_PIPE_PERF_EN
        input  perf_stall, perf_flush, perf_retired,
`endif
        output id_valid, id_ctrl, id_rs, id_rt, id_rd, ex_zero,
        input  stall_f, stall_d, flush_d, pcsrc_e, jump_d,
        input  ex_alusrc, ex_aluop, ex_regdst, fwd_a_e, fwd_b_e,
        input  mem_memwrite, mem_regwrite, mem_memtoreg, mem_writereg,
        input  wb_regwrite, wb_memtoreg, wb_writereg
    );

endinterface

// File: rtl/mips_ctrl_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_stage_reg
//   One pipeline stage register for the control slice: valid bit, ctrl_t and
//   NRA register numbers. Used for ID/EX (rs,rt,rd), EX/MEM and MEM/WB
//   (write register).
//   Ports: clk, reset (sync, active-high), en_i (advance), clr_i (load
//   bubble), valid_i/ctrl_i/ra_i (incoming stage), valid_o/ctrl_o/ra_o.
//   A non-valid entry is stored as all zeros so bubbles carry no stale
//   register numbers or controls downstream.
// -----------------------------------------------------------------------------
module mips_ctrl_stage_reg
    import mips_ctrl_pkg::*;
#(
    parameter int RA_W = 5,
    parameter int NRA  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en_i,
    input  logic                      clr_i,
    input  logic                      valid_i,
    input  ctrl_t                     ctrl_i,
    input  logic [NRA-1:0][RA_W-1:0]  ra_i,
    output logic                      valid_o,
    output ctrl_t                     ctrl_o,
    output logic [NRA-1:0][RA_W-1:0]  ra_o
);

    logic                     valid_q, valid_d;
    ctrl_t                    ctrl_q, ctrl_d;
    logic [NRA-1:0][RA_W-1:0] ra_q, ra_d;

    // Next-state: bubble on clear, capture (zeroed if not valid) on enable, else hold.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        ra_d    = ra_q;
        if (clr_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            ra_d    = '0;
        end else if (en_i) begin
            if (valid_i) begin
                valid_d = 1'b1;
                ctrl_d  = ctrl_i;
                ra_d    = ra_i;
            end else begin
                valid_d = 1'b0;
                ctrl_d  = '0;
                ra_d    = '0;
            end
        end else begin
            valid_d = valid_q;
            ctrl_d  = ctrl_q;
            ra_d    = ra_q;
        end
    end

    // Stage state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            ra_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            ra_q    <= ra_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign ra_o    = ra_q;

endmodule

// File: rtl/mips_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pipe
//   Carries decoded controls ID->EX->MEM->WB, detects load-use hazards
//   (stall), resolves beq/bne in EX (flush), and produces EX forwarding
//   selects.
//   Ports:
//     clk    : pipeline clock, all state on rising edge
//     reset  : synchronous, active-high; clears all stage state
//     bus    : mips_ctrl_pipe_if.slave (ID inputs, ex_zero, all controls)
//   Parameters: RA_W (register address width), PERF_W (perf counter width).
//   Optional macro CTRL_PIPE_PERF_EN: saturating counters for load-use
//   cycles, flush_d cycles and WB-valid (retired) cycles.
// -----------------------------------------------------------------------------
module mips_ctrl_pipe
    import mips_ctrl_pkg::*;
#(
    parameter int RA_W   = 5,
    parameter int PERF_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    mips_ctrl_pipe_if.slave    bus
);

    localparam logic [RA_W-1:0] REG_ZERO = '0;

    // Stage outputs
    logic                     ex_valid_s, mem_valid_s, wb_valid_s;
    ctrl_t                    ex_ctrl_s, mem_ctrl_s, wb_ctrl_s;
    logic [2:0][RA_W-1:0]     ex_ra_s;     // [2]=rs, [1]=rt, [0]=rd
    logic [RA_W-1:0]          ex_rs_s, ex_rt_s, ex_rd_s;
    logic [RA_W-1:0]          ex_writereg_s, mem_writereg_s, wb_writereg_s;

    // Hazard / forwarding
    logic                     lu_s, pcsrc_s, jump_s;
    logic                     stall_s, flush_s, idex_clr_s;
    logic                     mem_hit_a_s, wb_hit_a_s, mem_hit_b_s, wb_hit_b_s;
    logic                     mem_wr_ok_s, wb_wr_ok_s;
    logic                     unused_wb_s;

    assign ex_rs_s = ex_ra_s[2];
    assign ex_rt_s = ex_ra_s[1];
    assign ex_rd_s = ex_ra_s[0];

    assign ex_writereg_s = ex_ctrl_s.regdst ? ex_rd_s : ex_rt_s;

    // ---------------- stage registers ----------------
    mips_ctrl_stage_reg #(.RA_W(RA_W), .NRA(3)) u_id_ex (
        .clk     (clk),
        .reset   (reset),
        .en_i    (1'b1),
        .clr_i   (idex_clr_s),
        .valid_i (bus.id_valid),
        .ctrl_i  (bus.id_ctrl),
        .ra_i    ({bus.id_rs, bus.id_rt, bus.id_rd}),
        .valid_o (ex_valid_s),
        .ctrl_o  (ex_ctrl_s),
        .ra_o    (ex_ra_s)
    );

    mips_ctrl_stage_reg #(.RA_W(RA_W), .NRA(1)) u_ex_mem (
        .clk     (clk),
        .reset   (reset),
        .en_i    (1'b1),
        .clr_i   (1'b0),
        .valid_i (ex_valid_s),
        .ctrl_i  (ex_ctrl_s),
        .ra_i    (ex_writereg_s),
        .valid_o (mem_valid_s),
        .ctrl_o  (mem_ctrl_s),
        .ra_o    (mem_writereg_s)
    );

    mips_ctrl_stage_reg #(.RA_W(RA_W), .NRA(1)) u_mem_wb (
        .clk     (clk),
        .reset   (reset),
        .en_i    (1'b1),
        .clr_i   (1'b0),
        .valid_i (mem_valid_s),
        .ctrl_i  (mem_ctrl_s),
        .ra_i    (mem_writereg_s),
        .valid_o (wb_valid_s),
        .ctrl_o  (wb_ctrl_s),
        .ra_o    (wb_writereg_s)
    );

    // Only regwrite/memtoreg are consumed in WB; the rest of the bundle just rides along.
    assign unused_wb_s = ^wb_ctrl_s;

    // ---------------- hazard detection ----------------
    // rt is compared even for I-type instructions; a false stall costs one cycle only.
    assign lu_s = ex_valid_s & ex_ctrl_s.memtoreg & (ex_writereg_s != REG_ZERO)
                & ((ex_writereg_s == bus.id_rs) | (ex_writereg_s == bus.id_rt));

    assign pcsrc_s = ex_valid_s & ((ex_ctrl_s.branch & bus.ex_zero)
                                 | (ex_ctrl_s.bne & ~bus.ex_zero));

    assign jump_s = bus.id_valid & bus.id_ctrl.jump;

    // Stall/flush priority: a taken branch kills ID, so stalling it would be pointless.
    always_comb begin
        stall_s    = 1'b0;
        flush_s    = 1'b0;
        idex_clr_s = 1'b0;
        if (pcsrc_s) begin
            stall_s    = 1'b0;
            flush_s    = 1'b1;
            idex_clr_s = 1'b1;
        end else if (lu_s) begin
            stall_s    = 1'b1;
            flush_s    = jump_s;
            idex_clr_s = 1'b1;
        end else begin
            stall_s    = 1'b0;
            flush_s    = jump_s;
            idex_clr_s = 1'b0;
        end
    end

    // ---------------- forwarding ----------------
    // $0 is hard-wired zero, so a producer targeting it must never be forwarded.
    assign mem_wr_ok_s = mem_valid_s & mem_ctrl_s.regwrite & (mem_writereg_s != REG_ZERO);
    assign wb_wr_ok_s  = wb_valid_s  & wb_ctrl_s.regwrite  & (wb_writereg_s  != REG_ZERO);

    assign mem_hit_a_s = mem_wr_ok_s & (mem_writereg_s == ex_rs_s);
    assign wb_hit_a_s  = wb_wr_ok_s  & (wb_writereg_s  == ex_rs_s);
    assign mem_hit_b_s = mem_wr_ok_s & (mem_writereg_s == ex_rt_s);
    assign wb_hit_b_s  = wb_wr_ok_s  & (wb_writereg_s  == ex_rt_s);

    assign bus.fwd_a_e = fwd_select(mem_hit_a_s, wb_hit_a_s);
    assign bus.fwd_b_e = fwd_select(mem_hit_b_s, wb_hit_b_s);

    // ---------------- outputs (all gated by stage valid) ----------------
    assign bus.stall_f      = stall_s;
    assign bus.stall_d      = stall_s;
    assign bus.flush_d      = flush_s;
    assign bus.pcsrc_e      = pcsrc_s;
    assign bus.jump_d       = jump_s;

    assign bus.ex_alusrc    = ex_valid_s & ex_ctrl_s.alusrc;
    assign bus.ex_aluop     = {2{ex_valid_s}} & ex_ctrl_s.aluop;
    assign bus.ex_regdst    = ex_valid_s & ex_ctrl_s.regdst;

    assign bus.mem_memwrite = mem_valid_s & mem_ctrl_s.memwrite;
    assign bus.mem_regwrite = mem_valid_s & mem_ctrl_s.regwrite;
    assign bus.mem_memtoreg = mem_valid_s & mem_ctrl_s.memtoreg;
    assign bus.mem_writereg = {RA_W{mem_valid_s}} & mem_writereg_s;

    assign bus.wb_regwrite  = wb_valid_s & wb_ctrl_s.regwrite;
    assign bus.wb_memtoreg  = wb_valid_s & wb_ctrl_s.memtoreg;
    assign bus.wb_writereg  = {RA_W{wb_valid_s}} & wb_writereg_s;

`ifdef CTRL_PIPE_PERF_EN
    localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};
    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

    logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
    logic [PERF_W-1:0] perf_flush_q, perf_flush_d;
    logic [PERF_W-1:0] perf_ret_q,   perf_ret_d;

    // Saturating event counters.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        perf_ret_d   = perf_ret_q;
        if (lu_s && (perf_stall_q != PERF_MAX)) begin
            perf_stall_d = perf_stall_q + PERF_ONE;
        end else begin
            perf_stall_d = perf_stall_q;
        end
        if (flush_s && (perf_flush_q != PERF_MAX)) begin
            perf_flush_d = perf_flush_q + PERF_ONE;
        end else begin
            perf_flush_d = perf_flush_q;
        end
        if (wb_valid_s && (perf_ret_q != PERF_MAX)) begin
            perf_ret_d = perf_ret_q + PERF_ONE;
        end else begin
            perf_ret_d = perf_ret_q;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_ret_q   <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
            perf_ret_q   <= perf_ret_d;
        end
    end

    assign bus.perf_stall   = perf_stall_q;
    assign bus.perf_flush   = perf_flush_q;
    assign bus.perf_retired = perf_ret_q;
`else
    localparam int perf_w_unused = PERF_W;
`endif

endmodule

// File: tb/tb_mips_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// tb_mips_ctrl_pipe
//   Directed vector table, hand-written reset sequence and randomized
//   stimulus, all compared against an instruction-level pipeline model.
// -----------------------------------------------------------------------------
module tb_mips_ctrl_pipe;
    import mips_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_ctrl_pipe_if #(.RA_W(5), .PERF_W(32)) bus ();

    mips_ctrl_pipe #(.RA_W(5), .PERF_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Control bundles {regwrite,regdst,alusrc,branch,bne,memwrite,memtoreg,jump,aluop}
    localparam ctrl_t C_NOP = 10'b0_0_0_0_0_0_0_0_00;
    localparam ctrl_t C_ADD = 10'b1_1_0_0_0_0_0_0_10;
    localparam ctrl_t C_LW  = 10'b1_0_1_0_0_0_1_0_00;
    localparam ctrl_t C_BEQ = 10'b0_0_0_1_0_0_0_0_01;
    localparam ctrl_t C_BNE = 10'b0_0_0_0_1_0_0_0_01;
    localparam ctrl_t C_J   = 10'b0_0_0_0_0_0_0_1_00;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // One record per in-flight instruction: what it is and which register it writes.
    typedef struct packed {
        logic       v;
        ctrl_t      c;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dest;
    } ins_t;

    ins_t pl [3];   // 0 = EX, 1 = MEM, 2 = WB
    logic [31:0] m_stall, m_flush, m_ret;

    function automatic logic m_writes(input int s, input logic [4:0] r);
        return pl[s].v && pl[s].c.regwrite && (r != 5'd0) && (pl[s].dest == r);
    endfunction

    // Newest producer of r among older instructions in flight.
    function automatic logic [1:0] m_fwd(input logic [4:0] r);
        for (int s = 1; s <= 2; s++) begin
            if (m_writes(s, r)) return (s == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic logic m_lu();
        return pl[0].v && pl[0].c.memtoreg && (pl[0].dest != 5'd0)
            && ((pl[0].dest == bus.id_rs) || (pl[0].dest == bus.id_rt));
    endfunction

    function automatic logic m_pc();
        return pl[0].v && ((pl[0].c.branch && bus.ex_zero) || (pl[0].c.bne && !bus.ex_zero));
    endfunction

    function automatic logic [27:0] all_outs();
        return {bus.stall_f, bus.stall_d, bus.flush_d, bus.pcsrc_e, bus.jump_d,
                bus.ex_alusrc, bus.ex_aluop, bus.ex_regdst, bus.fwd_a_e, bus.fwd_b_e,
                bus.mem_memwrite, bus.mem_regwrite, bus.mem_memtoreg, bus.mem_writereg,
                bus.wb_regwrite, bus.wb_memtoreg, bus.wb_writereg};
    endfunction

    task automatic model_check();
        logic lu, pc, jmp, st, fl;
        lu  = m_lu();
        pc  = m_pc();
        jmp = bus.id_valid && bus.id_ctrl.jump;
        st  = lu && !pc;
        fl  = pc || jmp;
        chk("hazard", {bus.stall_f, bus.stall_d, bus.flush_d, bus.pcsrc_e, bus.jump_d},
            {st, st, fl, pc, jmp});
        chk("ex_ctrl", {bus.ex_alusrc, bus.ex_aluop, bus.ex_regdst},
            pl[0].v ? {pl[0].c.alusrc, pl[0].c.aluop, pl[0].c.regdst} : 4'b0000);
        chk("fwd", {bus.fwd_a_e, bus.fwd_b_e}, {m_fwd(pl[0].rs), m_fwd(pl[0].rt)});
        chk("mem_ctrl", {bus.mem_memwrite, bus.mem_regwrite, bus.mem_memtoreg, bus.mem_writereg},
            pl[1].v ? {pl[1].c.memwrite, pl[1].c.regwrite, pl[1].c.memtoreg, pl[1].dest} : 8'h00);
        chk("wb_ctrl", {bus.wb_regwrite, bus.wb_memtoreg, bus.wb_writereg},
            pl[2].v ? {pl[2].c.regwrite, pl[2].c.memtoreg, pl[2].dest} : 7'h00);
`ifdef CTRL_PIPE_PERF_EN
        chk("perf", {bus.perf_stall, bus.perf_flush}, {m_stall, m_flush});
        chk("perf_retired", bus.perf_retired, m_ret);
`endif
    endtask

    task automatic model_advance();
        logic lu, pc, jmp;
        lu  = m_lu();
        pc  = m_pc();
        jmp = bus.id_valid && bus.id_ctrl.jump;
        if (reset) begin
            for (int s = 0; s < 3; s++) pl[s] = '0;
            m_stall = 32'd0;
            m_flush = 32'd0;
            m_ret   = 32'd0;
        end else begin
            m_stall = m_stall + {31'd0, lu};
            m_flush = m_flush + {31'd0, (pc || jmp)};
            m_ret   = m_ret + {31'd0, pl[2].v};
            pl[2] = pl[1];
            pl[1] = pl[0];
            if (pc || lu || !bus.id_valid) begin
                pl[0] = '0;
            end else begin
                pl[0] = '{v: 1'b1, c: bus.id_ctrl, rs: bus.id_rs, rt: bus.id_rt,
                          dest: bus.id_ctrl.regdst ? bus.id_rd : bus.id_rt};
            end
        end
    endtask

    task automatic set_in(input logic v, input ctrl_t c, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic z);
        bus.id_valid = v;
        bus.id_ctrl  = c;
        bus.id_rs    = rs;
        bus.id_rt    = rt;
        bus.id_rd    = rd;
        bus.ex_zero  = z;
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       v;
        ctrl_t      c;
        logic [4:0] rs, rt, rd;
        logic       z;
        logic       stall, flush, pc, jmp;
        logic [1:0] fa, fb;
        logic       wbrw;
    } vec_t;

    vec_t tab [17];

    initial begin
        //        v     ctrl   rs     rt     rd     z    stall flush pc  jmp  fa     fb     wbrw
        tab[0]  = '{1'b1, C_LW,  5'd1,  5'd2,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        tab[1]  = '{1'b1, C_ADD, 5'd2,  5'd4,  5'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        tab[2]  = '{1'b1, C_ADD, 5'd2,  5'd4,  5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        tab[3]  = '{1'b1, C_ADD, 5'd6,  5'd7,  5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1};
        tab[4]  = '{1'b1, C_ADD, 5'd5,  5'd5,  5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        tab[5]  = '{1'b1, C_ADD, 5'd9,  5'd9,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b1};
        tab[6]  = '{1'b1, C_ADD, 5'd0,  5'd0,  5'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1};
        tab[7]  = '{1'b1, C_BEQ, 5'd1,  5'd1,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1};
        tab[8]  = '{1'b1, C_ADD, 5'd12, 5'd13, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1};
        tab[9]  = '{1'b1, C_BNE, 5'd1,  5'd1,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1};
        tab[10] = '{1'b0, C_NOP, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        tab[11] = '{1'b1, C_J,   5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0};
        tab[12] = '{1'b0, C_NOP, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        tab[13] = '{1'b1, C_ADD, 5'd1,  5'd2,  5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        tab[14] = '{1'b1, C_ADD, 5'd3,  5'd4,  5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        tab[15] = '{1'b1, C_ADD, 5'd7,  5'd7,  5'd14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
        tab[16] = '{1'b0, C_NOP, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b1};
    end

    // ---------------- main sequence ----------------
    initial begin
        for (int s = 0; s < 3; s++) pl[s] = '0;
        m_stall = 32'd0;
        m_flush = 32'd0;
        m_ret   = 32'd0;
        reset = 1'b1;
        set_in(1'b0, C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        sample();
        chk("reset_state", {4'h0, all_outs()}, 32'h0);
        advance();
        reset = 1'b0;

        // Directed table: load-use, forwarding, $0, branches, jump, MEM priority.
        for (int i = 0; i < 17; i++) begin
            set_in(tab[i].v, tab[i].c, tab[i].rs, tab[i].rt, tab[i].rd, tab[i].z);
            sample();
            chk($sformatf("tab%0d_hazard", i),
                {bus.stall_f, bus.stall_d, bus.flush_d, bus.pcsrc_e, bus.jump_d},
                {tab[i].stall, tab[i].stall, tab[i].flush, tab[i].pc, tab[i].jmp});
            chk($sformatf("tab%0d_fwd", i), {bus.fwd_a_e, bus.fwd_b_e}, {tab[i].fa, tab[i].fb});
            chk($sformatf("tab%0d_wb_regwrite", i), bus.wb_regwrite, tab[i].wbrw);
            advance();
        end

        // Reset held two cycles mid-stream with a LW sitting in EX.
        set_in(1'b1, C_LW, 5'd1, 5'd2, 5'd0, 1'b0);
        sample();
        advance();
        set_in(1'b0, C_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
        reset = 1'b1;
        sample();
        chk("lw_in_ex_before_reset", bus.ex_alusrc, 1'b1);
        advance();
        sample();
        advance();
        reset = 1'b0;
        sample();
        chk("reset_midstream_outputs", {4'h0, all_outs()}, 32'h0);
        advance();
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("no_write_after_reset", {bus.mem_regwrite, bus.wb_regwrite}, 2'b00);
            advance();
        end

        // Randomized stimulus against the model; small register range to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            set_in($urandom_range(0, 3) != 0, ctrl_t'($urandom_range(0, 1023)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            sample();
            advance();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
